// File: rtl/jtframe_db15_pkg.sv
// Shared sizes and frame type for the DB15 joystick link emulator.
// A frame is two joystick words back to back, player 1 in the low half.
package jtframe_db15_pkg;
    localparam int DB15_JOYW = 12;
    localparam int DB15_BITS = 2 * DB15_JOYW;

    typedef logic [DB15_BITS-1:0] db15_frame_t;
endpackage

// File: rtl/jtframe_db15_if.sv
// DB15 serial joystick pins: the reader (master) drives clock and load, and the
// adapter (slave) returns the serial data.
interface jtframe_db15_if;
    logic JOY_CLK;
    logic JOY_LOAD;
    logic JOY_DATA;

    modport master (output JOY_CLK, output JOY_LOAD, input JOY_DATA);
    modport slave  (input JOY_CLK, input JOY_LOAD, output JOY_DATA);
endinterface

// File: rtl/jtframe_sync.sv
// One-bit multi-flop synchroniser for pins that are asynchronous to clk.
// RST_VAL lets each pin start from its idle level.
module jtframe_sync #(
    parameter int   SYNCW   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic [SYNCW-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {SYNCW{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[SYNCW-2:0], din};
        end
    end

    assign dout = sync_reg[SYNCW-1];
endmodule

// File: rtl/jtframe_db15_emu.sv
// Emulates the 74HC165 chain of a DB15 adapter: latches two joystick words while
// JOY_LOAD is low and shifts them out LSB-first, active-low, on JOY_CLK rises.
module jtframe_db15_emu
    import jtframe_db15_pkg::*;
#(
    parameter int JOYW  = DB15_JOYW,
    parameter int SYNCW = 2,
    localparam int BITS = 2 * JOYW,
    localparam int CW   = $clog2(BITS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [JOYW-1:0] joy1,
    input  logic [JOYW-1:0] joy2,
    jtframe_db15_if.slave   db15,
    output logic            frame_done,
    output logic            overrun,
    output logic [CW-1:0]   bit_cnt
);
    logic            clk_s;
    logic            load_n_s;
    logic            clk_prev_reg;
    logic            shift;
    logic [BITS-1:0] sr_reg;
    logic [BITS-1:0] sr_next;
    logic            data_reg;
    logic [CW-1:0]   cnt_reg;
    logic            frame_done_reg;
    logic            overrun_reg;

    jtframe_sync #(.SYNCW(SYNCW), .RST_VAL(1'b0)) u_sync_clk (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (db15.JOY_CLK),
        .dout (clk_s)
    );

    jtframe_sync #(.SYNCW(SYNCW), .RST_VAL(1'b1)) u_sync_load (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (db15.JOY_LOAD),
        .dout (load_n_s)
    );

    // Edges seen while loading are consumed so no phantom shift follows the load.
    assign shift = clk_s & ~clk_prev_reg & load_n_s;

    always_comb begin
        sr_next = sr_reg;
        if (!load_n_s) begin
            sr_next = ~{joy2, joy1};
        end else if (shift) begin
            sr_next = {1'b1, sr_reg[BITS-1:1]};
        end
    end

    // JOY_DATA registers the next head bit so the pin updates in the same cycle as sr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev_reg   <= 1'b0;
            sr_reg         <= '1;
            data_reg       <= 1'b1;
            cnt_reg        <= '0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            clk_prev_reg   <= clk_s;
            sr_reg         <= sr_next;
            data_reg       <= sr_next[0];
            frame_done_reg <= shift && (cnt_reg == CW'(BITS - 1));
            if (!load_n_s) begin
                cnt_reg     <= '0;
                overrun_reg <= 1'b0;
            end else if (shift) begin
                if (cnt_reg == CW'(BITS)) begin
                    overrun_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign db15.JOY_DATA = data_reg;
    assign frame_done    = frame_done_reg;
    assign overrun       = overrun_reg;
    assign bit_cnt       = cnt_reg;
endmodule

// File: tb/tb_jtframe_db15_emu.sv
// Scoreboard bench for jtframe_db15_emu: stimulus updates a frame-level model and
// queues expected pin states; a negedge monitor compares them when they fall due.
module tb_jtframe_db15_emu;
    import jtframe_db15_pkg::*;

    localparam int JOYW  = DB15_JOYW;
    localparam int BITS  = DB15_BITS;
    localparam int SYNCW = 2;
    localparam int CW    = $clog2(BITS + 1);
    localparam int LAT   = SYNCW + 1;

    typedef struct {
        int    due;
        logic  data;
        int    cnt;
        logic  ovr;
        int    fd;
        string tag;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [JOYW-1:0] joy1 = '0;
    logic [JOYW-1:0] joy2 = '0;
    logic            frame_done;
    logic            overrun;
    logic [CW-1:0]   bit_cnt;

    jtframe_db15_if link ();

    jtframe_db15_emu #(.JOYW(JOYW), .SYNCW(SYNCW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .joy1      (joy1),
        .joy2      (joy2),
        .db15      (link.slave),
        .frame_done(frame_done),
        .overrun   (overrun),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    // Frame-level model: the latched frame, how many shifts since load, flags.
    db15_frame_t m_frame = '1;
    int          m_shifts = 0;
    logic        m_ovr = 1'b0;
    int          m_fd = 0;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   fd_seen = 0;

    function automatic logic m_data();
        return (m_shifts < BITS) ? m_frame[m_shifts] : 1'b1;
    endfunction

    function automatic int m_cnt();
        return (m_shifts < BITS) ? m_shifts : BITS;
    endfunction

    task automatic push(input string tag, input int due);
        exp_t e;
        e.due  = due;
        e.data = m_data();
        e.cnt  = m_cnt();
        e.ovr  = m_ovr;
        e.fd   = m_fd;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (frame_done === 1'b1) fd_seen++;
        if (exp_q.size() > 0 && cycle >= exp_q[0].due) begin
            e = exp_q.pop_front();
            check({e.tag, ".data"}, int'(link.JOY_DATA), int'(e.data));
            check({e.tag, ".cnt"}, int'(bit_cnt), e.cnt);
            check({e.tag, ".ovr"}, int'(overrun), int'(e.ovr));
            check({e.tag, ".fd"}, fd_seen, e.fd);
            $display("txn %-10s cycle=%0d data=%0b cnt=%0d ovr=%0b fd=%0d",
                     e.tag, cycle, link.JOY_DATA, bit_cnt, overrun, fd_seen);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        joy1 = JOYW'($urandom);
        joy2 = JOYW'($urandom);
        link.JOY_CLK  = 1'($urandom);
        link.JOY_LOAD = 1'($urandom);
        m_frame = '1;
        m_shifts = 0;
        m_ovr = 1'b0;
        push("reset", cycle + 1);
        tick(3);
        link.JOY_CLK  = 1'b0;
        link.JOY_LOAD = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic do_load(input logic [JOYW-1:0] j1, input logic [JOYW-1:0] j2,
                           input bit clk_during);
        joy1 = j1;
        joy2 = j2;
        link.JOY_LOAD = 1'b0;
        m_frame = ~{j2, j1};
        m_shifts = 0;
        m_ovr = 1'b0;
        push("load", cycle + LAT);
        tick(4);
        if (clk_during) begin
            link.JOY_CLK = 1'b1;
            tick(LAT + 2);
            push("load_clk", cycle + 1);
            link.JOY_CLK = 1'b0;
            tick(3);
        end
        link.JOY_LOAD = 1'b1;
        tick(LAT + 2);
        push("loaded", cycle + 1);
        tick(2);
    endtask

    task automatic do_shift();
        link.JOY_CLK = 1'b1;
        if (m_shifts >= BITS) m_ovr = 1'b1;
        if (m_shifts == BITS - 1) m_fd++;
        m_shifts++;
        push("shift", cycle + LAT);
        tick(4);
        link.JOY_CLK = 1'b0;
        tick(4);
    endtask

    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) do_shift();
    endtask

    initial begin
        link.JOY_CLK  = 1'b0;
        link.JOY_LOAD = 1'b1;
        tick(1);
        do_reset();

        // Frame with a pressed bit at each end of the chain
        do_load(12'h001, 12'h800, 1'b0);
        shifts(BITS);

        // Over-length read: fill bits and sticky overrun, cleared by the next load
        do_load(12'h001, 12'h800, 1'b0);
        shifts(BITS + 2);

        // Clock activity during load must not shift
        do_load(JOYW'($urandom), JOYW'($urandom), 1'b1);
        shifts(3);

        // Inputs changing mid-frame are not sampled
        do_load(12'h000, 12'h000, 1'b0);
        shifts(5);
        joy1 = 12'hFFF;
        shifts(BITS - 5);

        // Reset mid-frame, then a clean frame afterwards
        do_load(JOYW'($urandom), JOYW'($urandom), 1'b0);
        shifts(10);
        do_reset();
        do_load(JOYW'($urandom), JOYW'($urandom), 1'b0);
        shifts(BITS);

        for (int f = 0; f < 6; f++) begin
            do_load(JOYW'($urandom), JOYW'($urandom), 1'($urandom_range(0, 1)));
            shifts(int'($urandom_range(BITS - 4, BITS + 3)));
        end

        for (int w = 0; w < 50 && exp_q.size() > 0; w++) tick(1);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
